// File: rtl/mem_access_seq.sv
// Multicycle memory-port sequencer: arbitrates exception, data and fetch
// requests onto one port and drives the address mux select, write strobe and done pulses.
module mem_access_seq #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fetch_req,
  input  logic       data_req,
  input  logic       data_src,
  input  logic       data_wr,
  input  logic       exc_req,
  input  logic [1:0] exc_code,
  output logic [2:0] mem_sel,
  output logic       mem_wr,
  output logic       busy,
  output logic       fetch_done,
  output logic       data_done,
  output logic       exc_done
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
  typedef enum logic [1:0] {WHO_FETCH, WHO_DATA, WHO_EXC} who_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t     state_q, state_d;
  who_t       who_q, who_d;
  logic [3:0] cnt_q, cnt_d;
  logic       wr_q, wr_d;
  logic [2:0] sel_q, sel_d;
  logic       mem_wr_q, mem_wr_d;
  logic       busy_q, busy_d;
  logic       fdone_q, fdone_d;
  logic       ddone_q, ddone_d;
  logic       edone_q, edone_d;
  logic       finish_s;

  // Next-state, select and strobe computation for the access sequence.
  always_comb begin
    state_d  = state_q;
    who_d    = who_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    sel_d    = sel_q;
    mem_wr_d = 1'b0;
    finish_s = 1'b0;
    case (state_q)
      IDLE: begin
        sel_d = 3'b000;
        wr_d  = 1'b0;
        if (exc_req && (exc_code != 2'b00)) begin
          who_d   = WHO_EXC;
          sel_d   = {1'b0, exc_code};
          state_d = ACCESS;
        end else if (data_req) begin
          who_d    = WHO_DATA;
          sel_d    = data_src ? 3'b101 : 3'b100;
          wr_d     = data_wr;
          mem_wr_d = data_wr;
          state_d  = ACCESS;
        end else if (fetch_req) begin
          who_d   = WHO_FETCH;
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (wr_q || (MEM_LAT == 1)) begin
          state_d  = DONE;
          finish_s = 1'b1;
        end else begin
          cnt_d   = LAT_M1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d  = DONE;
          finish_s = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      DONE: begin
        sel_d   = 3'b000;
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
      default: begin
        sel_d   = 3'b000;
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
    endcase
    busy_d  = (state_d != IDLE);
    fdone_d = finish_s && (who_q == WHO_FETCH);
    ddone_d = finish_s && (who_q == WHO_DATA);
    edone_d = finish_s && (who_q == WHO_EXC);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      who_q    <= WHO_FETCH;
      cnt_q    <= 4'd0;
      wr_q     <= 1'b0;
      sel_q    <= 3'b000;
      mem_wr_q <= 1'b0;
      busy_q   <= 1'b0;
      fdone_q  <= 1'b0;
      ddone_q  <= 1'b0;
      edone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      who_q    <= who_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      sel_q    <= sel_d;
      mem_wr_q <= mem_wr_d;
      busy_q   <= busy_d;
      fdone_q  <= fdone_d;
      ddone_q  <= ddone_d;
      edone_q  <= edone_d;
    end
  end

  assign mem_sel    = sel_q;
  assign mem_wr     = mem_wr_q;
  assign busy       = busy_q;
  assign fetch_done = fdone_q;
  assign data_done  = ddone_q;
  assign exc_done   = edone_q;

endmodule

// File: tb/tb_mem_access_seq.sv
// Table-driven bench for mem_access_seq; three instances (MEM_LAT = 2, 4, 1)
// share the same stimulus and are each checked against their own latency.
module tb_mem_access_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       fetch_req = 1'b0, data_req = 1'b0, data_src = 1'b0, data_wr = 1'b0, exc_req = 1'b0;
  logic [1:0] exc_code = 2'b00;

  logic [2:0] sel_w [3];
  logic       mw_w [3], busy_w [3], fd_w [3], dd_w [3], ed_w [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_access_seq #(.MEM_LAT((g == 0) ? 2 : ((g == 1) ? 4 : 1))) u_dut (
      .clk(clk), .reset(reset), .fetch_req(fetch_req), .data_req(data_req),
      .data_src(data_src), .data_wr(data_wr), .exc_req(exc_req), .exc_code(exc_code),
      .mem_sel(sel_w[g]), .mem_wr(mw_w[g]), .busy(busy_w[g]),
      .fetch_done(fd_w[g]), .data_done(dd_w[g]), .exc_done(ed_w[g])
    );
  end

  typedef struct {
    logic       exc;
    logic [1:0] code;
    logic       data;
    logic       src;
    logic       wr;
    logic       fetch;
    logic [2:0] sel;  // expected mem_sel of the winner
    logic       ewr;  // expected write access
    logic [1:0] who;  // 0 none, 1 fetch, 2 data, 3 exc
  } vec_t;

  vec_t vecs [11];

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 4 : 1);
  endfunction

  // {busy, mem_sel, mem_wr, fetch_done, data_done, exc_done}
  function automatic logic [7:0] get_out(input int i);
    return {busy_w[i], sel_w[i], mw_w[i], fd_w[i], dd_w[i], ed_w[i]};
  endfunction

  function automatic logic [7:0] exp_out(input vec_t v, input int lat_mem, input int c);
    int   lat;
    logic act;
    lat = v.ewr ? 1 : lat_mem;
    if (v.who == 2'd0) return 8'h00;
    act = (c <= lat);
    return {act, act ? v.sel : 3'b000, v.ewr && (c == 0),
            (c == lat) && (v.who == 2'd1), (c == lat) && (v.who == 2'd2),
            (c == lat) && (v.who == 2'd3)};
  endfunction

  task automatic check(input string name, input int i, input int c,
                       input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle%0d: got %b expected %b (busy,sel,wr,fd,dd,ed)",
               name, i, c, got, exp);
    end
  endtask

  task automatic clear_reqs();
    fetch_req = 1'b0; data_req = 1'b0; data_src = 1'b0;
    data_wr = 1'b0; exc_req = 1'b0; exc_code = 2'b00;
  endtask

  task automatic check_all_zero(input string name);
    for (int i = 0; i < 3; i++) check(name, i, 0, get_out(i), 8'h00);
  endtask

  // Requests are presented for one accepting edge only; the access must still complete.
  task automatic run_vec(input vec_t v, input string name);
    @(negedge clk);
    exc_req = v.exc; exc_code = v.code; data_req = v.data;
    data_src = v.src; data_wr = v.wr; fetch_req = v.fetch;
    @(posedge clk);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 0) clear_reqs();
      for (int i = 0; i < 3; i++) check(name, i, c, get_out(i), exp_out(v, lat_of(i), c));
    end
  endtask

  int   done_cyc [3];
  int   order_n;
  logic [1:0] order [3];

  initial begin
    //         exc   code   data  src   wr    fetch sel     ewr   who
    vecs[0]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 2'd1};
    vecs[1]  = '{1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 2'd3};
    vecs[2]  = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 3'b100, 1'b0, 2'd2};
    vecs[3]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 2'd1};
    vecs[4]  = '{1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 3'b101, 1'b1, 2'd2};
    vecs[5]  = '{1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 2'd3};
    vecs[6]  = '{1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 3'b011, 1'b0, 2'd3};
    vecs[7]  = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 2'd1};
    vecs[8]  = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 2'd0};
    vecs[9]  = '{1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 3'b101, 1'b0, 2'd2};
    vecs[10] = '{1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 3'b100, 1'b1, 2'd2};

    // Asynchronous reset before any clock edge.
    #2 reset = 1'b1;
    #1 check_all_zero("reset_async");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_all_zero("reset_idle");

    for (int n = 0; n < 11; n++) run_vec(vecs[n], $sformatf("vec%0d", n));

    // Held requests: served exc, data, fetch in turn on the MEM_LAT=2 instance.
    @(negedge clk);
    exc_req = 1'b1; exc_code = 2'b10; data_req = 1'b1; fetch_req = 1'b1;
    order_n = 0;
    for (int c = 0; c < 40 && order_n < 3; c++) begin
      @(negedge clk);
      if (ed_w[0]) begin order[order_n] = 2'd3; done_cyc[order_n] = c; order_n++; exc_req = 1'b0; end
      if (dd_w[0]) begin order[order_n] = 2'd2; done_cyc[order_n] = c; order_n++; data_req = 1'b0; end
      if (fd_w[0]) begin order[order_n] = 2'd1; done_cyc[order_n] = c; order_n++; fetch_req = 1'b0; end
    end
    clear_reqs();
    checks++;
    if (order_n != 3) begin
      errors++;
      $display("FAIL held_seq_count: got %0d done pulses expected 3", order_n);
    end else begin
      check("held_order", 0, 0, {2'b00, order[0], order[1], order[2]}, 8'b00_11_10_01);
      check("held_timing", 0, 0, 8'(done_cyc[2] - done_cyc[0]), 8'd8);
      check("held_spacing", 0, 0, 8'(done_cyc[1] - done_cyc[0]), 8'd4);
    end
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Reset in the middle of a MEM_LAT=4 read wait: no done pulse afterwards.
    @(negedge clk);
    data_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear_reqs();
    @(negedge clk);
    check("mid_wait_busy", 1, 2, get_out(1), 8'b1_100_0_000);
    #2 reset = 1'b1;
    #1 check_all_zero("reset_mid_wait");
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("post_reset_quiet", 1, c, get_out(1), 8'h00);
    end
    run_vec(vecs[9], "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
